dispatch_stage: RTL

//  Sits between renamer and the per-FU issue queues. Buffers renamed instructions in an in-order FIFO, routes the head to the

---
 rtl/dispatch_stage_pkg.sv | 30 +++
 rtl/dispatch_stage_if.sv | 56 +++++
 rtl/dispatch_stage_prn_busy_table.sv | 63 ++++++
 rtl/dispatch_stage.sv | 109 ++++++++++
 4 files changed

// File: rtl/dispatch_stage_pkg.sv
// Shared types and widths for the dispatch stage slice.
// Holds the configuration localparams, the PRN type and the packed
// dispatch_entry_t record that one FIFO slot stores.
package dispatch_stage_pkg;

  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int FU_COUNT     = 4;
  localparam int DEPTH        = 4;

  localparam int FU_SEL_BITS  = $clog2(FU_COUNT);
  localparam int PTR_BITS     = $clog2(DEPTH);
  localparam int PRN_COUNT    = 2 ** PRN_BITS;
  localparam int CLR_PORTS    = FU_COUNT * MAX_OPERANDS;

  typedef logic [PRN_BITS-1:0] prn_t;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]  inst_id;
    logic [31:0]              raw_instr;
    logic [63:0]              pc;
    logic [FU_SEL_BITS-1:0]   fu_sel;
    logic [MAX_OPERANDS-1:0]  src_valid;
    prn_t [MAX_OPERANDS-1:0]  src_prn;
    logic [MAX_OPERANDS-1:0]  dst_valid;
    prn_t [MAX_OPERANDS-1:0]  dst_prn;
  } dispatch_entry_t;

endpackage

// File: rtl/dispatch_stage_if.sv
// Bundle of every non-clock/reset signal around the dispatch stage.
//   in_*            : renamer -> dispatch handshake and instruction fields
//   set_prn_ready/
//   set_prn         : FU completion broadcasts (busy-bit clears)
//   iq_inst_valid/
//   iq_queue_ready  : one-hot offer to the issue queues and their backpressure
//   iq_*            : head-of-FIFO fields shared by all issue queues
// Modport slave is the dispatch stage's view, master is the surrounding
// pipeline's view.
interface dispatch_stage_if;
  import dispatch_stage_pkg::*;

  logic                                    in_valid;
  logic                                    in_ready;
  logic [INST_ID_BITS-1:0]                 in_inst_id;
  logic [31:0]                             in_raw_instr;
  logic [63:0]                             in_pc;
  logic [FU_SEL_BITS-1:0]                  in_fu_sel;
  logic [MAX_OPERANDS-1:0]                 in_src_valid;
  prn_t [MAX_OPERANDS-1:0]                 in_src_prn;
  logic [MAX_OPERANDS-1:0]                 in_dst_valid;
  prn_t [MAX_OPERANDS-1:0]                 in_dst_prn;

  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]   set_prn_ready;
  prn_t [FU_COUNT-1:0][MAX_OPERANDS-1:0]   set_prn;

  logic [FU_COUNT-1:0]                     iq_inst_valid;
  logic [FU_COUNT-1:0]                     iq_queue_ready;
  logic [INST_ID_BITS-1:0]                 iq_inst_id;
  logic [31:0]                             iq_raw_instr;
  logic [63:0]                             iq_pc;
  logic [MAX_OPERANDS-1:0]                 iq_prn_input_valid;
  logic [MAX_OPERANDS-1:0]                 iq_prn_input_ready;
  prn_t [MAX_OPERANDS-1:0]                 iq_prn_input;
  logic [MAX_OPERANDS-1:0]                 iq_prn_output_valid;
  prn_t [MAX_OPERANDS-1:0]                 iq_prn_output;

  modport master (
    output in_valid, in_inst_id, in_raw_instr, in_pc, in_fu_sel,
           in_src_valid, in_src_prn, in_dst_valid, in_dst_prn,
           set_prn_ready, set_prn, iq_queue_ready,
    input  in_ready, iq_inst_valid, iq_inst_id, iq_raw_instr, iq_pc,
           iq_prn_input_valid, iq_prn_input_ready, iq_prn_input,
           iq_prn_output_valid, iq_prn_output
  );

  modport slave (
    input  in_valid, in_inst_id, in_raw_instr, in_pc, in_fu_sel,
           in_src_valid, in_src_prn, in_dst_valid, in_dst_prn,
           set_prn_ready, set_prn, iq_queue_ready,
    output in_ready, iq_inst_valid, iq_inst_id, iq_raw_instr, iq_pc,
           iq_prn_input_valid, iq_prn_input_ready, iq_prn_input,
           iq_prn_output_valid, iq_prn_output
  );

endinterface

// File: rtl/dispatch_stage_prn_busy_table.sv
// prn_busy_table: one busy bit per physical register.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (all bits clear)
//   set_valid/prn   : mark a PRN busy (destinations of the enqueued instr)
//   clr_valid/prn   : mark a PRN free (flattened FU completion broadcasts)
//   lookup_prn      : PRNs to query
//   lookup_ready    : PRN is free now, or is being freed this very cycle
// Optional feature macro DISPATCH_ZERO_PRN_EN: PRN 0 is a hardwired zero
// register that is never busy and always looks ready.
module prn_busy_table
  import dispatch_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAX_OPERANDS-1:0]  set_valid,
  input  prn_t [MAX_OPERANDS-1:0]  set_prn,
  input  logic [CLR_PORTS-1:0]     clr_valid,
  input  prn_t [CLR_PORTS-1:0]     clr_prn,
  input  prn_t [MAX_OPERANDS-1:0]  lookup_prn,
  output logic [MAX_OPERANDS-1:0]  lookup_ready
);

  logic [PRN_COUNT-1:0]    busy;
  logic [PRN_COUNT-1:0]    busy_next;
  logic [MAX_OPERANDS-1:0] bypass_hit;

  // Clears are applied before sets so that a PRN both reallocated and
  // completed in the same cycle ends up busy (the new producer owns it).
  always_comb begin
    busy_next = busy;
    for (int c = 0; c < CLR_PORTS; c++) begin
      if (clr_valid[c]) busy_next[clr_prn[c]] = 1'b0;
    end
    for (int s = 0; s < MAX_OPERANDS; s++) begin
      if (set_valid[s]) busy_next[set_prn[s]] = 1'b1;
    end
`ifdef DISPATCH_ZERO_PRN_EN
    busy_next[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  // A completion broadcast in the lookup cycle counts as ready, otherwise
  // the wakeup would be lost for an instruction entering its IQ right now.
  always_comb begin
    bypass_hit   = '0;
    lookup_ready = '0;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      for (int c = 0; c < CLR_PORTS; c++) begin
        if (clr_valid[c] && (clr_prn[c] == lookup_prn[j])) bypass_hit[j] = 1'b1;
      end
      lookup_ready[j] = !busy[lookup_prn[j]] || bypass_hit[j];
`ifdef DISPATCH_ZERO_PRN_EN
      if (lookup_prn[j] == '0) lookup_ready[j] = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// dispatch_stage: in-order FIFO between the renamer and the per-FU issue
// queues. The head is offered to the IQ named by its fu_sel; source-operand
// ready bits come from the PRN busy table at the moment of insertion.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : dispatch_stage_if.slave (renamer handshake, completion
//          broadcasts, IQ offer/backpressure and head fields)
// Optional feature macro DISPATCH_ZERO_PRN_EN (see prn_busy_table).
module dispatch_stage
  import dispatch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  dispatch_stage_if.slave bus
);

  dispatch_entry_t         fifo_mem [DEPTH];
  logic [PTR_BITS:0]       wr_ptr;
  logic [PTR_BITS:0]       rd_ptr;
  logic                    empty;
  logic                    full;
  logic                    enq;
  logic                    deq;
  dispatch_entry_t         in_entry;
  dispatch_entry_t         head;
  logic [FU_COUNT-1:0]     offer;
  logic [MAX_OPERANDS-1:0] set_valid;
  logic [CLR_PORTS-1:0]    clr_valid;
  prn_t [CLR_PORTS-1:0]    clr_prn;
  logic [MAX_OPERANDS-1:0] lookup_ready;

  // Extra wrap bit tells full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]) &&
                 (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]);

  assign enq = bus.in_valid && !full;
  assign deq = !empty && bus.iq_queue_ready[head.fu_sel];

  always_comb begin
    in_entry           = '0;
    in_entry.inst_id   = bus.in_inst_id;
    in_entry.raw_instr = bus.in_raw_instr;
    in_entry.pc        = bus.in_pc;
    in_entry.fu_sel    = bus.in_fu_sel;
    in_entry.src_valid = bus.in_src_valid;
    in_entry.src_prn   = bus.in_src_prn;
    in_entry.dst_valid = bus.in_dst_valid;
    in_entry.dst_prn   = bus.in_dst_prn;
  end

  // Head reads as all-zero while empty so stale slots never leak onto the
  // IQ bus (also gives zeroed outputs straight out of reset).
  always_comb begin
    head = '0;
    if (!empty) head = fifo_mem[rd_ptr[PTR_BITS-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + (PTR_BITS+1)'(1);
      if (deq) rd_ptr <= rd_ptr + (PTR_BITS+1)'(1);
    end
  end

  // Storage needs no reset: its contents are only visible through head.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr[PTR_BITS-1:0]] <= in_entry;
  end

  always_comb begin
    offer = '0;
    if (!empty) offer[head.fu_sel] = 1'b1;
  end

  assign set_valid = enq ? bus.in_dst_valid : '0;
  assign clr_valid = bus.set_prn_ready;
  assign clr_prn   = bus.set_prn;

  prn_busy_table u_busy (
    .clk          (clk),
    .rst          (rst),
    .set_valid    (set_valid),
    .set_prn      (bus.in_dst_prn),
    .clr_valid    (clr_valid),
    .clr_prn      (clr_prn),
    .lookup_prn   (head.src_prn),
    .lookup_ready (lookup_ready)
  );

  assign bus.in_ready            = !full;
  assign bus.iq_inst_valid       = offer;
  assign bus.iq_inst_id          = head.inst_id;
  assign bus.iq_raw_instr        = head.raw_instr;
  assign bus.iq_pc               = head.pc;
  assign bus.iq_prn_input_valid  = head.src_valid;
  assign bus.iq_prn_input_ready  = head.src_valid & lookup_ready;
  assign bus.iq_prn_input        = head.src_prn;
  assign bus.iq_prn_output_valid = head.dst_valid;
  assign bus.iq_prn_output       = head.dst_prn;

  fu_sel_legal: assert property (@(posedge clk) disable iff (rst)
                                 enq |-> (int'(bus.in_fu_sel) < FU_COUNT));

endmodule
